// File: rtl/rpn_stack.sv
`default_nettype none
// ============================================================================
// Module  : rpn_stack
// Brief   : Operand stack for the RPN datapath with single-cycle stack ops,
//           top/next views, occupancy count and overflow/underflow reporting.
//           Option: RPN_STACK_STICKY_ERR_EN makes ovf/unf sticky until CLEAR.
// Revision: 1.0 - initial release
// ============================================================================
module rpn_stack #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [2:0]                 op,
    input  logic [WIDTH-1:0]           data_in,
    output logic [WIDTH-1:0]           top,
    output logic [WIDTH-1:0]           next,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty,
    output logic                       ovf,
    output logic                       unf
);

    localparam int CW = $clog2(DEPTH+1);
    localparam int IW = $clog2(DEPTH);

    localparam logic [2:0] c_OP_NOP     = 3'b000;
    localparam logic [2:0] c_OP_PUSH    = 3'b001;
    localparam logic [2:0] c_OP_POP     = 3'b010;
    localparam logic [2:0] c_OP_REPLACE = 3'b011;
    localparam logic [2:0] c_OP_DUP     = 3'b100;
    localparam logic [2:0] c_OP_SWAP    = 3'b101;
    localparam logic [2:0] c_OP_POP2    = 3'b110;
    localparam logic [2:0] c_OP_CLEAR   = 3'b111;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [CW-1:0]    r_count;
    logic             r_ovf;
    logic             r_unf;

    logic             w_full;
    logic             w_empty;
    logic             w_two;
    logic [IW-1:0]    w_top_idx;
    logic [IW-1:0]    w_next_idx;
    logic [IW-1:0]    w_push_idx;
    logic [WIDTH-1:0] w_top;
    logic [WIDTH-1:0] w_next;

    logic             w_we_a;
    logic [IW-1:0]    w_idx_a;
    logic [WIDTH-1:0] w_data_a;
    logic             w_we_b;
    logic [IW-1:0]    w_idx_b;
    logic [WIDTH-1:0] w_data_b;
    logic [CW-1:0]    w_count_nxt;
    logic             w_ovf;
    logic             w_unf;

    assign w_full  = (r_count == CW'(DEPTH));
    assign w_empty = (r_count == '0);
    assign w_two   = (r_count >= CW'(2));

    // Indices are forced in range whenever the slot they name does not exist.
    assign w_top_idx  = w_empty ? '0 : IW'(r_count - CW'(1));
    assign w_next_idx = w_two   ? IW'(r_count - CW'(2)) : '0;
    assign w_push_idx = w_full  ? '0 : IW'(r_count);

    assign w_top  = w_empty ? '0 : r_mem[w_top_idx];
    assign w_next = w_two   ? r_mem[w_next_idx] : '0;

    always_comb begin
        w_we_a      = 1'b0;
        w_idx_a     = '0;
        w_data_a    = '0;
        w_we_b      = 1'b0;
        w_idx_b     = '0;
        w_data_b    = '0;
        w_count_nxt = r_count;
        w_ovf       = 1'b0;
        w_unf       = 1'b0;
        case (op)
            c_OP_NOP: ;
            c_OP_PUSH: begin
                if (w_full) begin
                    w_ovf = 1'b1;
                end else begin
                    w_we_a      = 1'b1;
                    w_idx_a     = w_push_idx;
                    w_data_a    = data_in;
                    w_count_nxt = r_count + CW'(1);
                end
            end
            c_OP_POP: begin
                if (w_empty) w_unf = 1'b1;
                else         w_count_nxt = r_count - CW'(1);
            end
            c_OP_REPLACE: begin
                if (w_empty) begin
                    w_unf = 1'b1;
                end else begin
                    w_we_a   = 1'b1;
                    w_idx_a  = w_top_idx;
                    w_data_a = data_in;
                end
            end
            c_OP_DUP: begin
                if (w_empty) begin
                    w_unf = 1'b1;
                end else if (w_full) begin
                    w_ovf = 1'b1;
                end else begin
                    w_we_a      = 1'b1;
                    w_idx_a     = w_push_idx;
                    w_data_a    = w_top;
                    w_count_nxt = r_count + CW'(1);
                end
            end
            c_OP_SWAP: begin
                if (!w_two) begin
                    w_unf = 1'b1;
                end else begin
                    w_we_a   = 1'b1;
                    w_idx_a  = w_top_idx;
                    w_data_a = w_next;
                    w_we_b   = 1'b1;
                    w_idx_b  = w_next_idx;
                    w_data_b = w_top;
                end
            end
            c_OP_POP2: begin
                // The ALU result lands where "next" was; net effect is one pop.
                if (!w_two) begin
                    w_unf = 1'b1;
                end else begin
                    w_we_a      = 1'b1;
                    w_idx_a     = w_next_idx;
                    w_data_a    = data_in;
                    w_count_nxt = r_count - CW'(1);
                end
            end
            c_OP_CLEAR: w_count_nxt = '0;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin : p_mem
        if (w_we_a) r_mem[w_idx_a] <= w_data_a;
        if (w_we_b) r_mem[w_idx_b] <= w_data_b;
    end

    always_ff @(posedge clk or posedge rst) begin : p_state
        if (rst) begin
            r_count <= '0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
        end else begin
            r_count <= w_count_nxt;
`ifdef RPN_STACK_STICKY_ERR_EN
            if (op == c_OP_CLEAR) begin
                r_ovf <= 1'b0;
                r_unf <= 1'b0;
            end else begin
                r_ovf <= r_ovf | w_ovf;
                r_unf <= r_unf | w_unf;
            end
`else
            r_ovf <= w_ovf;
            r_unf <= w_unf;
`endif
        end
    end

    assign top   = w_top;
    assign next  = w_next;
    assign count = r_count;
    assign full  = w_full;
    assign empty = w_empty;
    assign ovf   = r_ovf;
    assign unf   = r_unf;

endmodule
`default_nettype wire

// File: tb/tb_rpn_stack.sv
`default_nettype none
// ============================================================================
// Module  : tb_rpn_stack
// Brief   : Directed and random checks of rpn_stack against a queue model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_rpn_stack;

    localparam int WIDTH = 32;
    localparam int DEPTH = 5;
    localparam int CW    = $clog2(DEPTH+1);

    localparam logic [2:0] NOP = 3'd0, PUSH = 3'd1, POP = 3'd2, REPL = 3'd3,
                           DUP = 3'd4, SWAP = 3'd5, P2P = 3'd6, CLR = 3'd7;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [2:0]       op = NOP;
    logic [WIDTH-1:0] data_in = '0;
    logic [WIDTH-1:0] top, next;
    logic [CW-1:0]    count;
    logic             full, empty, ovf, unf;

    int tests = 0;
    int fails = 0;

    logic [WIDTH-1:0] q[$];
    logic             m_ovf = 1'b0;
    logic             m_unf = 1'b0;

    rpn_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .op(op), .data_in(data_in),
        .top(top), .next(next), .count(count),
        .full(full), .empty(empty), .ovf(ovf), .unf(unf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all(input string ctx);
        logic [WIDTH-1:0] e_top, e_next;
        int n;
        n      = q.size();
        e_top  = (n > 0) ? q[n-1] : '0;
        e_next = (n > 1) ? q[n-2] : '0;
        chk({ctx, ".count"}, WIDTH'(count), WIDTH'(n));
        chk({ctx, ".top"},   top,  e_top);
        chk({ctx, ".next"},  next, e_next);
        chk({ctx, ".full"},  WIDTH'(full),  WIDTH'(n == DEPTH));
        chk({ctx, ".empty"}, WIDTH'(empty), WIDTH'(n == 0));
        chk({ctx, ".ovf"},   WIDTH'(ovf),   WIDTH'(m_ovf));
        chk({ctx, ".unf"},   WIDTH'(unf),   WIDTH'(m_unf));
    endtask

    // Reference behaviour expressed directly on a queue of entries.
    task automatic model(input logic [2:0] o, input logic [WIDTH-1:0] d);
        logic ro, ru;
        logic [WIDTH-1:0] t;
        int n;
        ro = 1'b0;
        ru = 1'b0;
        n  = q.size();
        case (o)
            PUSH: if (n == DEPTH) ro = 1'b1; else q.push_back(d);
            POP:  if (n == 0) ru = 1'b1; else void'(q.pop_back());
            REPL: if (n == 0) ru = 1'b1; else q[n-1] = d;
            DUP:  if (n == 0) ru = 1'b1; else if (n == DEPTH) ro = 1'b1; else q.push_back(q[n-1]);
            SWAP: if (n < 2) ru = 1'b1; else begin t = q[n-1]; q[n-1] = q[n-2]; q[n-2] = t; end
            P2P:  if (n < 2) ru = 1'b1; else begin void'(q.pop_back()); void'(q.pop_back()); q.push_back(d); end
            CLR:  q.delete();
            default: ;
        endcase
`ifdef RPN_STACK_STICKY_ERR_EN
        if (o == CLR) begin m_ovf = 1'b0; m_unf = 1'b0; end
        else begin m_ovf = m_ovf | ro; m_unf = m_unf | ru; end
`else
        m_ovf = ro;
        m_unf = ru;
`endif
    endtask

    task automatic step(input logic [2:0] o, input logic [WIDTH-1:0] d, input string ctx);
        op      = o;
        data_in = d;
        @(posedge clk);
        model(o, d);
        #1;
        check_all(ctx);
    endtask

    initial begin
        // Reset held from time zero, checked before any clock edge.
        #2;
        check_all("reset0");
        #5 rst = 1'b0;

        step(PUSH, 32'h11, "push11");
        step(PUSH, 32'h22, "push22");
        step(PUSH, 32'h33, "push33");
        step(SWAP, 32'h0,  "swap");
        step(P2P,  32'h55, "pop2push");

        step(CLR, 32'h0, "clr_a");
        for (int i = 0; i < DEPTH; i++) step(PUSH, 32'h100 + i, "fill");
        step(PUSH, 32'h99, "push_full");
        step(NOP,  32'h0,  "after_ovf");
        step(DUP,  32'h0,  "dup_full");
        step(NOP,  32'h0,  "after_dup_ovf");

        step(CLR,  32'h0, "clr_b");
        step(POP,  32'h0, "pop_empty");
        step(NOP,  32'h0, "after_pop_unf");
        step(REPL, 32'hAB, "repl_empty");
        step(NOP,  32'h0, "after_repl_unf");
        step(DUP,  32'h0, "dup_empty");
        step(PUSH, 32'h7, "push7");
        step(SWAP, 32'h0, "swap_one");
        step(NOP,  32'h0, "after_swap_unf");
        step(P2P,  32'h3, "p2p_one");
        step(NOP,  32'h0, "after_p2p_unf");

        step(CLR,  32'h0,  "clr_c");
        step(PUSH, 32'h1,  "p1");
        step(PUSH, 32'h2,  "p2");
        step(PUSH, 32'h3,  "p3");
        step(DUP,  32'h0,  "dup");
        step(REPL, 32'hAB, "repl");
        step(POP,  32'h0,  "pop");

        // Asynchronous reset between edges with four entries present.
        step(PUSH, 32'h4, "p4");
        #2 rst = 1'b1;
        q.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
        #1 check_all("async_rst");
        #1 rst = 1'b0;
        step(PUSH, 32'h1, "post_rst_push");

        for (int i = 0; i < 600; i++) begin
            logic [2:0] o;
            o = 3'($urandom_range(0, 7));
            if (o == CLR && $urandom_range(0, 3) != 0) o = PUSH;
            step(o, $urandom, "rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
